// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_LEN = 32;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DONE
  } state_e;

  // Index of the final byte of an access; the illegal size 3 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 2'd0;
      MEM_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one 8-bit RAM port between instruction fetch and load/store,
// assembling 32-bit reads and splitting stores into byte writes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic              lead_q, lead_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] ram_a_d;
  logic              ram_wr_d, if_done_d, mem_done_d;
  logic [7:0]        ram_dout_d;
  logic [31:0]       if_inst_d, mem_rdata_d;
  logic [1:0]        cnt_inc;

  assign cnt_inc = cnt_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    lead_d      = lead_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ram_a_d     = '0;
    ram_wr_d    = 1'b0;
    ram_dout_d  = '0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst;
    mem_rdata_d = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        lead_d = 1'b1;
        asm_d  = '0;
        if (mem_req) begin
          last_d  = last_idx(mem_size);
          wdata_d = mem_wdata;
          ram_a_d = mem_addr;
          if (mem_we) begin
            state_d    = ST_MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = ST_MEM_RD;
          end
        end else if (if_req && !if_cancel) begin
          last_d  = 2'd3;
          ram_a_d = if_addr;
          state_d = ST_IF_RD;
        end
      end

      // Reads: the first cycle only issues an address (RAM has one cycle of
      // latency); each later cycle captures one byte while issuing the next.
      ST_IF_RD, ST_MEM_RD: begin
        if (state_q == ST_IF_RD && if_cancel) begin
          state_d = ST_IDLE;
        end else if (lead_q) begin
          lead_d = 1'b0;
          if (last_q != 2'd0) ram_a_d = ram_a + 1'b1;
        end else begin
          asm_d = asm_q | (32'(ram_din) << {cnt_q, 3'b000});
          if (({1'b0, cnt_q} + 3'd1) < {1'b0, last_q}) ram_a_d = ram_a + 1'b1;
          if (cnt_q == last_q) begin
            state_d = ST_DONE;
            if (state_q == ST_IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = asm_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_d;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_MEM_WR: begin
        if (cnt_q == last_q) begin
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          ram_wr_d   = 1'b1;
          ram_a_d    = ram_a + 1'b1;
          ram_dout_d = 8'(wdata_q >> {cnt_inc, 3'b000});
        end
      end

      // One cycle with the done pulse up; no arbitration here.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      lead_q    <= 1'b0;
      wdata_q   <= '0;
      asm_q     <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      lead_q    <= lead_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      ram_a     <= ram_a_d;
      ram_wr    <= ram_wr_d;
      ram_dout  <= ram_dout_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
      if_inst   <= if_inst_d;
      mem_rdata <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 1 KiB byte RAM with one-cycle read latency plus a
// byte-array reference of memory contents and access timing rules.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req = 1'b0, if_cancel = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req = 1'b0, mem_we = 1'b0;
  logic [1:0]        mem_size = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [1024];
  logic [7:0]  init_img [1024];
  logic [7:0]  refm [1024];
  logic        load_init = 1'b0;

  logic [31:0] tr_a [10];
  logic        tr_w [10];
  int          tr_done;
  logic [31:0] tr_data;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_init) for (int i = 0; i < 1024; i++) ram[i] <= init_img[i];
    else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v, ak;
    v = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v[8*k +: 8] = refm[ak[9:0]];
    end
    return v;
  endfunction

  // Drives one request and records ram_a/ram_wr per access cycle c1..c10,
  // the cycle index of the done pulse and the returned data.
  task automatic run_access(input logic is_if, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    end
    tr_done = -1;
    tr_data = '0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      tr_a[j-1] = ram_a;
      tr_w[j-1] = ram_wr;
      if ((is_if ? if_done : mem_done) && tr_done < 0) begin
        tr_done = j;
        tr_data = is_if ? if_inst : mem_rdata;
        if_req  = 1'b0;
        mem_req = 1'b0;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ram_a !== '0) begin errors++; $display("FAIL reset_ram_a got %h want 0", ram_a); end
    checks++; if ({ram_wr, ram_dout} !== 9'd0) begin errors++; $display("FAIL reset_wr_dout got %b/%h want 0/00", ram_wr, ram_dout); end
    checks++; if ({if_done, mem_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b%b want 00", if_done, mem_done); end
    checks++; if ({if_inst, mem_rdata} !== 64'd0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", if_inst, mem_rdata); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ram_wr, if_done, mem_done} !== 3'b000) begin errors++; $display("FAIL post_reset_idle got %b want 000", {ram_wr, if_done, mem_done}); end
  endtask

  task automatic test_if_fetch;
    run_access(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    checks++; if (tr_done !== 6) begin errors++; $display("FAIL if_fetch_latency got %0d want 6", tr_done); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (tr_a[k] !== 32'h100 + 32'(k)) begin errors++; $display("FAIL if_fetch_addr c%0d got %h want %h", k+1, tr_a[k], 32'h100 + 32'(k)); end
      checks++; if (tr_w[k] !== 1'b0) begin errors++; $display("FAIL if_fetch_wr c%0d got %b want 0", k+1, tr_w[k]); end
    end
    checks++; if (tr_data !== 32'h0000_0513) begin errors++; $display("FAIL if_fetch_inst got %h want 00000513", tr_data); end
  endtask

  task automatic test_simultaneous;
    int md, id;
    logic [31:0] mdat, idat;
    md = -1; id = -1; mdat = '0; idat = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (mem_done && md < 0) begin md = j; mdat = mem_rdata; mem_req = 1'b0; end
      if (if_done && id < 0) begin id = j; idat = if_inst; if_req = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    checks++; if (md !== 6) begin errors++; $display("FAIL simul_mem_done got c%0d want c6", md); end
    checks++; if (id !== 13) begin errors++; $display("FAIL simul_if_done got c%0d want c13", id); end
    checks++; if (mdat !== ref_load(32'h200, 4)) begin errors++; $display("FAIL simul_mem_data got %h want %h", mdat, ref_load(32'h200, 4)); end
    checks++; if (idat !== 32'h0000_0513) begin errors++; $display("FAIL simul_if_inst got %h want 00000513", idat); end
  endtask

  task automatic test_store_half;
    run_access(1'b0, 1'b1, 2'd1, 32'h7, 32'hAABB_CCDD);
    checks++; if (tr_done !== 3) begin errors++; $display("FAIL store_half_latency got %0d want 3", tr_done); end
    checks++; if ({tr_w[0], tr_w[1], tr_w[2]} !== 3'b110) begin errors++; $display("FAIL store_half_wr got %b want 110", {tr_w[0], tr_w[1], tr_w[2]}); end
    checks++; if ({tr_a[0], tr_a[1]} !== {32'h7, 32'h8}) begin errors++; $display("FAIL store_half_addr got %h %h want 7 8", tr_a[0], tr_a[1]); end
    checks++; if ({ram[7], ram[8]} !== 16'hDDCC) begin errors++; $display("FAIL store_half_bytes got %h %h want DD CC", ram[7], ram[8]); end
    checks++; if (ram[9] !== refm[9]) begin errors++; $display("FAIL store_half_spill got %h want %h", ram[9], refm[9]); end
    refm[7] = 8'hDD; refm[8] = 8'hCC;
    run_access(1'b0, 1'b0, 2'd1, 32'h7, 32'h0);
    checks++; if (tr_done !== 4) begin errors++; $display("FAIL load_half_latency got %0d want 4", tr_done); end
    checks++; if (tr_data !== 32'h0000_CCDD) begin errors++; $display("FAIL load_half_data got %h want 0000CCDD", tr_data); end
  endtask

  task automatic test_cancel;
    logic seen;
    logic nonzero_a;
    seen = 1'b0; nonzero_a = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++; if (ram_a !== 32'h100) begin errors++; $display("FAIL cancel_c1_addr got %h want 100", ram_a); end
    if_cancel = 1'b1;
    @(negedge clk);
    if_req = 1'b0; if_cancel = 1'b0;
    checks++; if (ram_a !== '0) begin errors++; $display("FAIL cancel_addr_zero got %h want 0", ram_a); end
    for (int j = 0; j < 8; j++) begin
      if (if_done) seen = 1'b1;
      if (ram_a !== '0) nonzero_a = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_no_done got %b want 0", seen); end
    checks++; if (nonzero_a !== 1'b0) begin errors++; $display("FAIL cancel_idle got %b want 0", nonzero_a); end
    run_access(1'b1, 1'b0, 2'd2, 32'h200, 32'h0);
    checks++; if (tr_done !== 6) begin errors++; $display("FAIL refetch_latency got %0d want 6", tr_done); end
    checks++; if (tr_data !== ref_load(32'h200, 4)) begin errors++; $display("FAIL refetch_inst got %h want %h", tr_data, ref_load(32'h200, 4)); end
  endtask

  task automatic test_reset_mid_store;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({ram_wr, ram_a} !== {1'b1, 32'h301}) begin errors++; $display("FAIL mid_store_c2 got %b/%h want 1/301", ram_wr, ram_a); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({ram_wr, ram_a, ram_dout, if_done, mem_done} !== 43'd0) begin errors++; $display("FAIL reset_async got wr=%b a=%h d=%h", ram_wr, ram_a, ram_dout); end
    checks++; if ({if_inst, mem_rdata} !== 64'd0) begin errors++; $display("FAIL reset_async_data got %h/%h want 0/0", if_inst, mem_rdata); end
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ram[10'h300] !== 8'h44) begin errors++; $display("FAIL mid_store_byte0 got %h want 44", ram[10'h300]); end
    checks++; if (ram[10'h301] !== refm[10'h301]) begin errors++; $display("FAIL mid_store_byte1 got %h want %h", ram[10'h301], refm[10'h301]); end
    refm[10'h300] = 8'h44;
    run_access(1'b0, 1'b0, 2'd2, 32'h300, 32'h0);
    checks++; if (tr_done !== 6) begin errors++; $display("FAIL after_reset_latency got %0d want 6", tr_done); end
    checks++; if (tr_data !== ref_load(32'h300, 4)) begin errors++; $display("FAIL after_reset_data got %h want %h", tr_data, ref_load(32'h300, 4)); end
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    run_access(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);
    for (int k = 0; k < 4; k++) begin
      e = 32'hFFFF_FFFE + 32'(k);
      checks++; if (tr_a[k] !== e) begin errors++; $display("FAIL wrap_addr c%0d got %h want %h", k+1, tr_a[k], e); end
    end
    checks++; if (tr_data !== ref_load(32'hFFFF_FFFE, 4)) begin errors++; $display("FAIL wrap_data got %h want %h", tr_data, ref_load(32'hFFFF_FFFE, 4)); end
  endtask

  task automatic test_random;
    logic        isif, we;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp, ak;
    int          n, bad;
    for (int i = 0; i < 30; i++) begin
      isif = ($urandom_range(0, 3) == 0);
      we   = !isif && ($urandom_range(0, 1) == 1);
      sz   = 2'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 1023));
      wd   = $urandom;
      n    = isif ? 4 : nb(sz);
      exp  = ref_load(a, n);
      run_access(isif, we, sz, a, wd);
      checks++; if (tr_done !== (we ? n + 1 : n + 2)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, tr_done, we ? n + 1 : n + 2); end
      for (int k = 0; k < n; k++) begin
        checks++; if ({tr_w[k], tr_a[k]} !== {we, a + 32'(k)}) begin errors++; $display("FAIL rand%0d_c%0d got %b/%h want %b/%h", i, k+1, tr_w[k], tr_a[k], we, a + 32'(k)); end
      end
      if (we) begin
        checks++; if (tr_w[n] !== 1'b0) begin errors++; $display("FAIL rand%0d_wr_end got %b want 0", i, tr_w[n]); end
        for (int k = 0; k < n; k++) begin
          ak = a + 32'(k);
          refm[ak[9:0]] = wd[8*k +: 8];
        end
      end else begin
        checks++; if (tr_data !== exp) begin errors++; $display("FAIL rand%0d_data got %h want %h", i, tr_data, exp); end
      end
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== refm[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ram_image got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      init_img[i] = 8'($urandom);
    end
    init_img[10'h100] = 8'h13; init_img[10'h101] = 8'h05;
    init_img[10'h102] = 8'h00; init_img[10'h103] = 8'h00;
    for (int i = 0; i < 1024; i++) refm[i] = init_img[i];
    load_init = 1'b1;
    @(posedge clk);
    #1 load_init = 1'b0;

    test_reset();
    test_if_fetch();
    test_simultaneous();
    test_store_half();
    test_cancel();
    test_reset_mid_store();
    test_wrap();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
